load_store_unit: RTL and testbench
==================================

# load_store_unit

Sits between the CPU datapath and the byte-addressed, big-endian, word-wide data `memory`, and turns byte, halfword and word load/store requests into memory accesses. Loads return results zero- or sign-extended. Sub-word stores use read-modify-write, because the memory only writes whole 4-byte groups. The unit checks alignment and range before touching memory, and handles one request at a time with a single-cycle response pulse.

## Interface
- `MEM_BYTES`, default 64: memory size in bytes. Addresses at or above this value are out of range.
- `clk` input, 1 bit: clock.
- `rst` input, 1 bit: reset, asynchronous, active-high.
- `req` input, 1 bit: request valid; accepted only when `ready`=1.
- `we` input, 1 bit: 1 = store, 0 = load.
- `size` input, 2 bits: 00 byte, 01 halfword, 10 word, 11 illegal.
- `sign_ext` input, 1 bit: loads only; 1 = sign-extend, 0 = zero-extend.
- `addr` input, 32 bits: byte address.
- `wdata` input, 32 bits: store data, right-justified (byte in [7:0], halfword in [15:0]).
- `ready` output, 1 bit: unit idle and able to accept `req`.
- `resp_valid` output, 1 bit: one-cycle completion pulse.
- `resp_err` output, 1 bit: valid with `resp_valid`; request rejected, memory untouched.
- `resp_rdata` output, 32 bits: load result, valid with `resp_valid`; 0 for stores and errors.
- `m_addr` output, 32 bits: memory word address, always `addr & ~3` of the latched request.
- `m_wdata` output, 32 bits: memory write data.
- `m_wenable` output, 1 bit: memory write strobe, sampled on `clk` rising edge.
- `m_renable` output, 1 bit: memory read strobe; `m_rdata` is valid the cycle after.
- `m_rdata` input, 32 bits: memory read data, registered inside the memory.

## Operation
- Byte order is big-endian. Lane `addr[1:0]`=0 is bits [31:24] and lane 3 is bits [7:0]. A halfword at offset 0 occupies [31:16]; at offset 2 it occupies [15:0].
- On acceptance (`req`&`ready`), `we`, `size`, `sign_ext`, `addr` and `wdata` are latched. Later input changes are ignored until the unit returns to IDLE.
- Error checks are evaluated on the latched request:
  - `size`=11 is an error.
  - A halfword with `addr[0]`=1 is an error.
  - A word with `addr[1:0]`≠0 is an error.
  - `addr` ≥ `MEM_BYTES` is an error.
- State machine (encoding free):
  - IDLE: `ready`=1. On accept: error → RESP (err=1); word store → WRITE; load or sub-word store → READ.
  - READ: `m_renable`=1. Next state is EXT for a load, MERGE for a store.
  - EXT: extract the lane from `m_rdata`, extend it, register it into `resp_rdata` → RESP.
  - MERGE: `m_wenable`=1. `m_wdata` is `m_rdata` with the target lane(s) replaced by `wdata[7:0]` or `wdata[15:0]` → RESP.
  - WRITE: `m_wenable`=1, `m_wdata`=`wdata` → RESP.
  - RESP: `resp_valid`=1 → IDLE.
- `m_renable` and `m_wenable` are never both 1. Both are 0 outside READ, MERGE and WRITE.
- `m_wdata`=0 outside MERGE and WRITE.

## Timing
- Request accepted at edge T (cycle T is IDLE with `req`=1).
- `resp_valid` is high for exactly one cycle:
  - error: cycle T+1
  - word store: cycle T+2 (write lands at the edge ending WRITE)
  - load: cycle T+3
  - sub-word store: cycle T+3
- The RESP cycle has `ready`=0. IDLE follows, so back-to-back requests are spaced latency+1 cycles apart.
- There is no backpressure on the response; the consumer must take the pulse.
- Reset (asynchronous, any state, including mid-READ or mid-MERGE):
  - state → IDLE, latched request discarded.
  - Outputs go to `ready`=1 and everything else 0 (`resp_valid`, `resp_err`, `resp_rdata`, `m_addr`, `m_wdata`, `m_wenable`, `m_renable`).
  - An interrupted RMW performs no write.

## Test plan
- After reset, load word at 8 → `resp_rdata`=0x00000002 at T+3, `resp_err`=0. Load word at 28 → 0x00000007.
- Load byte unsigned at 7 → 0x00000001. Store word 0xA1B2C3F4 at 4, then load byte signed at 7 → 0xFFFFFFF4 and unsigned at 4 → 0x000000A1.
- Store byte 0x80 at 13 (one `m_renable` cycle, then one `m_wenable` cycle with `m_addr`=12, `m_wdata`=0x00800003). Then load word at 12 → 0x00800003, and load byte signed at 13 → 0xFFFFFF80.
- Store halfword 0xBEEF at 18. Load halfword signed at 18 → 0xFFFFBEEF; zero-extended → 0x0000BEEF; load word at 16 → 0x0000BEEF.
- Error cases each give `resp_err`=1 at T+1 with no memory strobe:
  - word at 6
  - halfword at 9
  - `size`=11
  - `addr`=64
- Assert `rst` during MERGE of a byte store at 13, then load word at 12 → 0x00000003 (reset contents, no partial write). Also check `resp_valid` never asserts for the aborted request.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit
// Bridges CPU byte/halfword/word load-store requests onto a big-endian,
// word-wide data memory. Sub-word stores are done as read-modify-write.
// One request is handled at a time; completion is a single-cycle pulse.
module load_store_unit #(
   parameter int unsigned MEM_BYTES = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_i,
   input  logic        we_i,
   input  logic [1:0]  size_i,
   input  logic        sign_ext_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic        ready_o,
   output logic        resp_valid_o,
   output logic        resp_err_o,
   output logic [31:0] resp_rdata_o,
   output logic [31:0] m_addr_o,
   output logic [31:0] m_wdata_o,
   output logic        m_wenable_o,
   output logic        m_renable_o,
   input  logic [31:0] m_rdata_i
);

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_EXT,
      S_MERGE,
      S_WRITE,
      S_RESP
   } state_e;

   state_e      state_q, state_d;
   logic        we_q;
   logic [1:0]  size_q;
   logic        sign_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic        err_q;
   logic [31:0] rdata_q, rdata_d;
   logic        accept;

   // Illegal size, misalignment for the access width, or beyond the end of memory.
   function automatic logic req_error(input logic [1:0] sz, input logic [31:0] a);
      logic e;
      e = 1'b0;
      if (sz == 2'b11)                      e = 1'b1;
      if (sz == SZ_HALF && a[0])            e = 1'b1;
      if (sz == SZ_WORD && a[1:0] != 2'b00) e = 1'b1;
      if (a >= MEM_BYTES)                   e = 1'b1;
      return e;
   endfunction

   // Pick the addressed lane(s) out of a big-endian word and extend to 32 bits.
   function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] sz,
                                           input logic [1:0] off, input logic sx);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      case (off)
         2'd0:    b = w[31:24];
         2'd1:    b = w[23:16];
         2'd2:    b = w[15:8];
         default: b = w[7:0];
      endcase
      h = off[1] ? w[15:0] : w[31:16];
      case (sz)
         SZ_BYTE: r = sx ? {{24{b[7]}}, b} : {24'h0, b};
         SZ_HALF: r = sx ? {{16{h[15]}}, h} : {16'h0, h};
         default: r = w;
      endcase
      return r;
   endfunction

   // Replace the addressed lane(s) of the old memory word with the store data.
   function automatic logic [31:0] merge(input logic [31:0] w, input logic [31:0] d,
                                         input logic [1:0] sz, input logic [1:0] off);
      logic [31:0] r;
      r = w;
      case (sz)
         SZ_BYTE: begin
            case (off)
               2'd0:    r[31:24] = d[7:0];
               2'd1:    r[23:16] = d[7:0];
               2'd2:    r[15:8]  = d[7:0];
               default: r[7:0]   = d[7:0];
            endcase
         end
         SZ_HALF: begin
            if (off[1]) r[15:0]  = d[15:0];
            else        r[31:16] = d[15:0];
         end
         default: r = d;
      endcase
      return r;
   endfunction

   assign accept       = req_i && (state_q == S_IDLE);
   assign m_addr_o     = {addr_q[31:2], 2'b00};
   assign resp_rdata_o = rdata_q;

   // Capture the request on acceptance; it stays frozen until the next accept.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: registers assigned with <= so every flop samples pre-edge values;
      // only control/data registers are reset here, the data memory lives outside.
      if (rst) begin
         we_q    <= 1'b0;
         size_q  <= 2'b00;
         sign_q  <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         err_q   <= 1'b0;
      end else if (accept) begin
         we_q    <= we_i;
         size_q  <= size_i;
         sign_q  <= sign_ext_i;
         addr_q  <= addr_i;
         wdata_q <= wdata_i;
         err_q   <= req_error(size_i, addr_i);
      end
   end

   // State register and the registered load result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         rdata_q <= rdata_d;
      end
   end

   // Next-state logic and Moore outputs for the access sequencer.
   always_comb begin
      // NOTE: every output gets a default first so no path through the case infers a latch.
      state_d      = state_q;
      rdata_d      = rdata_q;
      ready_o      = 1'b0;
      resp_valid_o = 1'b0;
      resp_err_o   = 1'b0;
      m_renable_o  = 1'b0;
      m_wenable_o  = 1'b0;
      m_wdata_o    = '0;
      case (state_q)
         S_IDLE: begin
            ready_o = 1'b1;
            if (req_i) begin
               if (req_error(size_i, addr_i))       state_d = S_RESP;
               else if (we_i && size_i == SZ_WORD)  state_d = S_WRITE;
               else                                 state_d = S_READ;
            end
         end
         S_READ: begin
            m_renable_o = 1'b1;
            state_d     = we_q ? S_MERGE : S_EXT;
         end
         S_EXT: begin
            rdata_d = extract(m_rdata_i, size_q, addr_q[1:0], sign_q);
            state_d = S_RESP;
         end
         S_MERGE: begin
            m_wenable_o = 1'b1;
            m_wdata_o   = merge(m_rdata_i, wdata_q, size_q, addr_q[1:0]);
            state_d     = S_RESP;
         end
         S_WRITE: begin
            m_wenable_o = 1'b1;
            m_wdata_o   = wdata_q;
            state_d     = S_RESP;
         end
         S_RESP: begin
            resp_valid_o = 1'b1;
            resp_err_o   = err_q;
            rdata_d      = '0;
            state_d      = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: word-wide memory model plus a byte-level
// big-endian reference model; directed scenarios followed by random traffic.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_i = 1'b0;
   logic        we_i = 1'b0;
   logic [1:0]  size_i = 2'b00;
   logic        sign_ext_i = 1'b0;
   logic [31:0] addr_i = '0;
   logic [31:0] wdata_i = '0;
   logic        ready_o, resp_valid_o, resp_err_o, m_wenable_o, m_renable_o;
   logic [31:0] resp_rdata_o, m_addr_o, m_wdata_o;
   logic [31:0] m_rdata_i = '0;

   int errors = 0;
   int checks = 0;

   // Memory contents at start: word i holds the value i.
   logic [31:0] mem [16] = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7,
                             32'd8, 32'd9, 32'd10, 32'd11, 32'd12, 32'd13, 32'd14, 32'd15};
   // Reference model: plain byte array, byte 4*i+3 = i, others 0.
   logic [7:0]  rm [64];

   load_store_unit #(.MEM_BYTES(64)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_i        (req_i),
      .we_i         (we_i),
      .size_i       (size_i),
      .sign_ext_i   (sign_ext_i),
      .addr_i       (addr_i),
      .wdata_i      (wdata_i),
      .ready_o      (ready_o),
      .resp_valid_o (resp_valid_o),
      .resp_err_o   (resp_err_o),
      .resp_rdata_o (resp_rdata_o),
      .m_addr_o     (m_addr_o),
      .m_wdata_o    (m_wdata_o),
      .m_wenable_o  (m_wenable_o),
      .m_renable_o  (m_renable_o),
      .m_rdata_i    (m_rdata_i)
   );

   always #5 clk = ~clk;

   // Synchronous memory: registered read data, whole-word writes.
   always @(posedge clk) begin
      if (m_wenable_o) mem[m_addr_o[5:2]] <= m_wdata_o;
      if (m_renable_o) m_rdata_i <= mem[m_addr_o[5:2]];
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1);
   end

   function automatic logic ref_err(input logic [1:0] sz, input logic [31:0] a);
      return (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0) || (a >= 64);
   endfunction

   function automatic logic [31:0] ref_word(input logic [31:0] a);
      return {rm[a], rm[a + 1], rm[a + 2], rm[a + 3]};
   endfunction

   function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic sx, input logic [31:0] a);
      logic [31:0] v;
      if (sz == 2'd0) begin
         v = 32'(rm[a]);
         if (sx && rm[a] >= 8'h80) v = v - 32'h100;
      end else if (sz == 2'd1) begin
         v = 32'({rm[a], rm[a + 1]});
         if (sx && v >= 32'h8000) v = v - 32'h10000;
      end else begin
         v = ref_word(a);
      end
      return v;
   endfunction

   task automatic ref_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
      if (sz == 2'd0) begin
         rm[a] = d[7:0];
      end else if (sz == 2'd1) begin
         rm[a] = d[15:8]; rm[a + 1] = d[7:0];
      end else begin
         rm[a] = d[31:24]; rm[a + 1] = d[23:16]; rm[a + 2] = d[15:8]; rm[a + 3] = d[7:0];
      end
   endtask

   // Issue one request, follow it for up to 6 cycles and compare against the model.
   task automatic run_op(input string tag, input logic we, input logic [1:0] sz, input logic sx,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output logic [31:0] wr_data);
      logic        exp_err, got_err, bad_strobe, bad_addr;
      int          exp_lat, exp_nr, exp_nw, lat, nr, nw;
      logic [31:0] exp_rd, exp_wr, exp_maddr;
      exp_err   = ref_err(sz, a);
      exp_maddr = a & ~32'd3;
      exp_rd    = '0;
      exp_wr    = '0;
      if (!exp_err && !we) exp_rd = ref_load(sz, sx, a);
      if (!exp_err && we) begin
         ref_store(sz, a, wd);
         exp_wr = ref_word(exp_maddr);
      end
      exp_lat = exp_err ? 1 : ((we && sz == 2'd2) ? 2 : 3);
      exp_nr  = (!exp_err && !(we && sz == 2'd2)) ? 1 : 0;
      exp_nw  = (!exp_err && we) ? 1 : 0;

      @(negedge clk);
      checks++;
      if (ready_o !== 1'b1) begin
         errors++; $display("FAIL %s ready_idle: got %b want 1", tag, ready_o);
      end
      req_i = 1'b1; we_i = we; size_i = sz; sign_ext_i = sx; addr_i = a; wdata_i = wd;
      @(posedge clk);
      lat = 0; nr = 0; nw = 0; got_err = 1'b0; bad_strobe = 1'b0; bad_addr = 1'b0;
      rd = '0; wr_data = '0;
      for (int k = 1; k <= 6 && lat == 0; k++) begin
         @(negedge clk);
         if (k == 1) begin
            req_i = 1'b0; we_i = 1'($urandom); size_i = 2'($urandom);
            sign_ext_i = 1'($urandom); addr_i = $urandom; wdata_i = $urandom;
         end
         if (m_renable_o === 1'b1) begin
            nr++;
            if (m_addr_o !== exp_maddr) bad_addr = 1'b1;
         end
         if (m_wenable_o === 1'b1) begin
            nw++;
            wr_data = m_wdata_o;
            if (m_addr_o !== exp_maddr) bad_addr = 1'b1;
         end
         if (m_renable_o === 1'b1 && m_wenable_o === 1'b1) bad_strobe = 1'b1;
         if (m_wenable_o !== 1'b1 && m_wdata_o !== 32'h0) bad_strobe = 1'b1;
         if (resp_valid_o === 1'b1) begin
            lat = k; got_err = resp_err_o; rd = resp_rdata_o;
            if (ready_o !== 1'b0) bad_strobe = 1'b1;
         end
      end
      checks++;
      if (lat != exp_lat) begin
         errors++; $display("FAIL %s latency: got %0d want %0d", tag, lat, exp_lat);
      end
      checks++;
      if (got_err !== exp_err) begin
         errors++; $display("FAIL %s resp_err: got %b want %b", tag, got_err, exp_err);
      end
      checks++;
      if (rd !== exp_rd) begin
         errors++; $display("FAIL %s resp_rdata: got %08h want %08h", tag, rd, exp_rd);
      end
      checks++;
      if (nr != exp_nr || nw != exp_nw) begin
         errors++; $display("FAIL %s strobes: got rd=%0d wr=%0d want rd=%0d wr=%0d", tag, nr, nw, exp_nr, exp_nw);
      end
      checks++;
      if (wr_data !== exp_wr) begin
         errors++; $display("FAIL %s m_wdata: got %08h want %08h", tag, wr_data, exp_wr);
      end
      checks++;
      if (bad_addr || bad_strobe) begin
         errors++; $display("FAIL %s bus_rules: got addr_bad=%b strobe_bad=%b want 0 0", tag, bad_addr, bad_strobe);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({ready_o, resp_valid_o, resp_err_o, m_wenable_o, m_renable_o} !== 5'b10000 ||
          resp_rdata_o !== 32'h0 || m_addr_o !== 32'h0 || m_wdata_o !== 32'h0) begin
         errors++;
         $display("FAIL reset_state: got rdy=%b v=%b e=%b we=%b re=%b rd=%08h ma=%08h wd=%08h want 1 0 0 0 0 0 0 0",
                  ready_o, resp_valid_o, resp_err_o, m_wenable_o, m_renable_o, resp_rdata_o, m_addr_o, m_wdata_o);
      end
      rst = 1'b0;
   endtask

   task automatic test_abort_rmw;
      logic [31:0] rd, wr;
      int          seen;
      @(negedge clk);
      req_i = 1'b1; we_i = 1'b1; size_i = 2'd0; sign_ext_i = 1'b0; addr_i = 32'd13; wdata_i = 32'h80;
      @(posedge clk);
      @(negedge clk);
      req_i = 1'b0;
      checks++;
      if (m_renable_o !== 1'b1) begin
         errors++; $display("FAIL abort_read_phase: got m_renable=%b want 1", m_renable_o);
      end
      @(negedge clk);
      checks++;
      if (m_wenable_o !== 1'b1 || m_wdata_o !== 32'h00800003) begin
         errors++; $display("FAIL abort_merge_phase: got we=%b wd=%08h want 1 00800003", m_wenable_o, m_wdata_o);
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({ready_o, resp_valid_o, resp_err_o, m_wenable_o, m_renable_o} !== 5'b10000 ||
          resp_rdata_o !== 32'h0 || m_addr_o !== 32'h0 || m_wdata_o !== 32'h0) begin
         errors++;
         $display("FAIL abort_outputs: got rdy=%b v=%b we=%b re=%b ma=%08h wd=%08h want 1 0 0 0 0 0",
                  ready_o, resp_valid_o, m_wenable_o, m_renable_o, m_addr_o, m_wdata_o);
      end
      seen = 0;
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (resp_valid_o === 1'b1) seen++;
      end
      checks++;
      if (seen != 0) begin
         errors++; $display("FAIL abort_no_resp: got %0d pulses want 0", seen);
      end
      run_op("abort_load12", 1'b0, 2'd2, 1'b0, 32'd12, 32'h0, rd, wr);
      checks++;
      if (rd !== 32'h00000003) begin
         errors++; $display("FAIL abort_word12: got %08h want 00000003", rd);
      end
   endtask

   task automatic test_loads;
      logic [31:0] rd, wr;
      run_op("load_w8", 1'b0, 2'd2, 1'b0, 32'd8, 32'h0, rd, wr);
      checks++;
      if (rd !== 32'h00000002) begin errors++; $display("FAIL load_w8_const: got %08h want 00000002", rd); end
      run_op("load_w28", 1'b0, 2'd2, 1'b0, 32'd28, 32'h0, rd, wr);
      checks++;
      if (rd !== 32'h00000007) begin errors++; $display("FAIL load_w28_const: got %08h want 00000007", rd); end
      run_op("load_bu7", 1'b0, 2'd0, 1'b0, 32'd7, 32'h0, rd, wr);
      checks++;
      if (rd !== 32'h00000001) begin errors++; $display("FAIL load_bu7_const: got %08h want 00000001", rd); end
   endtask

   task automatic test_store_word;
      logic [31:0] rd, wr;
      run_op("store_w4", 1'b1, 2'd2, 1'b0, 32'd4, 32'hA1B2C3F4, rd, wr);
      run_op("load_bs7", 1'b0, 2'd0, 1'b1, 32'd7, 32'h0, rd, wr);
      checks++;
      if (rd !== 32'hFFFFFFF4) begin errors++; $display("FAIL load_bs7_const: got %08h want FFFFFFF4", rd); end
      run_op("load_bu4", 1'b0, 2'd0, 1'b0, 32'd4, 32'h0, rd, wr);
      checks++;
      if (rd !== 32'h000000A1) begin errors++; $display("FAIL load_bu4_const: got %08h want 000000A1", rd); end
   endtask

   task automatic test_store_byte;
      logic [31:0] rd, wr;
      run_op("store_b13", 1'b1, 2'd0, 1'b0, 32'd13, 32'h80, rd, wr);
      checks++;
      if (wr !== 32'h00800003) begin errors++; $display("FAIL store_b13_wdata: got %08h want 00800003", wr); end
      run_op("load_w12", 1'b0, 2'd2, 1'b0, 32'd12, 32'h0, rd, wr);
      checks++;
      if (rd !== 32'h00800003) begin errors++; $display("FAIL load_w12_const: got %08h want 00800003", rd); end
      run_op("load_bs13", 1'b0, 2'd0, 1'b1, 32'd13, 32'h0, rd, wr);
      checks++;
      if (rd !== 32'hFFFFFF80) begin errors++; $display("FAIL load_bs13_const: got %08h want FFFFFF80", rd); end
   endtask

   task automatic test_store_half;
      logic [31:0] rd, wr;
      run_op("store_h18", 1'b1, 2'd1, 1'b0, 32'd18, 32'h1234BEEF, rd, wr);
      run_op("load_hs18", 1'b0, 2'd1, 1'b1, 32'd18, 32'h0, rd, wr);
      checks++;
      if (rd !== 32'hFFFFBEEF) begin errors++; $display("FAIL load_hs18_const: got %08h want FFFFBEEF", rd); end
      run_op("load_hu18", 1'b0, 2'd1, 1'b0, 32'd18, 32'h0, rd, wr);
      checks++;
      if (rd !== 32'h0000BEEF) begin errors++; $display("FAIL load_hu18_const: got %08h want 0000BEEF", rd); end
      run_op("load_w16", 1'b0, 2'd2, 1'b0, 32'd16, 32'h0, rd, wr);
      checks++;
      if (rd !== 32'h0000BEEF) begin errors++; $display("FAIL load_w16_const: got %08h want 0000BEEF", rd); end
   endtask

   task automatic test_errors;
      logic [31:0] rd, wr;
      run_op("err_w6", 1'b0, 2'd2, 1'b0, 32'd6, 32'h0, rd, wr);
      run_op("err_h9", 1'b1, 2'd1, 1'b0, 32'd9, 32'hFFFF, rd, wr);
      run_op("err_sz3", 1'b0, 2'd3, 1'b0, 32'd0, 32'h0, rd, wr);
      run_op("err_a64", 1'b1, 2'd2, 1'b0, 32'd64, 32'h5555AAAA, rd, wr);
      run_op("err_b64", 1'b0, 2'd0, 1'b0, 32'd64, 32'h0, rd, wr);
      run_op("ok_b63", 1'b0, 2'd0, 1'b1, 32'd63, 32'h0, rd, wr);
   endtask

   task automatic test_random;
      logic [31:0] rd, wr, a;
      logic [1:0]  sz;
      int          r;
      for (int i = 0; i < 300; i++) begin
         r  = $urandom_range(0, 9);
         sz = (r == 0) ? 2'd3 : 2'(r % 3);
         case ($urandom_range(0, 9))
            0:       a = $urandom;
            1:       a = 32'($urandom_range(64, 71));
            default: a = 32'($urandom_range(0, 63));
         endcase
         if ($urandom_range(0, 3) != 0) begin
            if (sz == 2'd1) a = a & ~32'd1;
            if (sz == 2'd2) a = a & ~32'd3;
         end
         run_op("random", 1'($urandom), sz, 1'($urandom), a, $urandom, rd, wr);
      end
   endtask

   task automatic test_back_to_back;
      logic [31:0] rd, wr;
      // Store then immediately load the same bytes with no idle gap.
      run_op("b2b_sw", 1'b1, 2'd2, 1'b0, 32'd40, 32'h8001FF7E, rd, wr);
      run_op("b2b_lh", 1'b0, 2'd1, 1'b1, 32'd40, 32'h0, rd, wr);
      checks++;
      if (rd !== 32'hFFFF8001) begin errors++; $display("FAIL b2b_lh_const: got %08h want FFFF8001", rd); end
      run_op("b2b_sb", 1'b1, 2'd0, 1'b0, 32'd43, 32'hAB, rd, wr);
      run_op("b2b_lw", 1'b0, 2'd2, 1'b0, 32'd40, 32'h0, rd, wr);
      checks++;
      if (rd !== 32'h8001FFAB) begin errors++; $display("FAIL b2b_lw_const: got %08h want 8001FFAB", rd); end
   endtask

   initial begin
      for (int i = 0; i < 64; i++) rm[i] = (i % 4 == 3) ? 8'(i / 4) : 8'h00;
      test_reset();
      test_abort_rmw();
      test_loads();
      test_store_word();
      test_store_byte();
      test_store_half();
      test_errors();
      test_back_to_back();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
